mem_controller: RTL and testbench

- Responder end of the load/store-buffer memory request interface.
- Accepts one read or write request at a time from the load/store buffer and performs it as a byte-serial sequence on the 8-bit external RAM/IO bus.
- Returns a one-cycle completion pulse, plus read data for reads.
- Sits between the load/store buffer and the top-level RAM port.

---
 rtl/mem_controller_if.sv | 37 +++
 rtl/mem_controller.sv | 150 +++++++++++++++
 tb/tb_mem_controller.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_controller_if.sv
// mem_controller_if: request/response and byte-bus signals of the memory controller.
//   LSBMC_*         : request from the load/store buffer (valid, rd/wr, width, data, address)
//   MCLSB_*         : completion pulses and read data back to the load/store buffer
//   mem_*           : 8-bit external RAM/IO bus (address, write data, write strobe, read data)
//   io_buffer_full  : IO sink back-pressure for writes into the IO region
// Modport slave is the controller's view; modport master is the requester/RAM side.
interface mem_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  LSBMC_en;
  logic                  LSBMC_wr;
  logic [2:0]            LSBMC_data_width;
  logic [31:0]           LSBMC_data;
  logic [ADDR_WIDTH-1:0] LSBMC_addr;
  logic                  MCLSB_r_en;
  logic                  MCLSB_w_en;
  logic [31:0]           MCLSB_data;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_data, LSBMC_addr,
    input  mem_din, io_buffer_full,
    output MCLSB_r_en, MCLSB_w_en, MCLSB_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_data, LSBMC_addr,
    output mem_din, io_buffer_full,
    input  MCLSB_r_en, MCLSB_w_en, MCLSB_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: serves one load/store-buffer request at a time as a byte-serial
// sequence on the 8-bit RAM/IO bus, then returns a one-cycle completion pulse.
// Ports:
//   Sys_clk   : clock, rising edge
//   Sys_rst_n : asynchronous active-low reset
//   Sys_rdy   : global enable; low freezes all state and masks mem_wr
//   bus       : mem_controller_if.slave (request, completion and RAM bus signals)
module mem_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input  logic              Sys_clk,
  input  logic              Sys_rst_n,
  input  logic              Sys_rdy,
  mem_controller_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [2:0]            n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           rd_buf;
  logic [31:0]           rd_next;
  logic [31:0]           rdata_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            dout_q;
  logic                  mem_wr_q;
  logic                  r_en_q;
  logic                  w_en_q;

  logic [2:0]            cnt_inc;
  logic [2:0]            last_cnt;
  logic [2:0]            n_dec;
  logic [ADDR_WIDTH-1:0] next_a;
  logic [7:0]            next_byte;
  logic                  stall_new;
  logic                  stall_cur;

  assign cnt_inc   = cnt + 3'd1;
  assign last_cnt  = n_q - 3'd1;
  assign next_a    = addr_q + ADDR_WIDTH'(cnt_inc);
  assign next_byte = data_q[{cnt_inc[1:0], 3'b000} +: 8];

  // IO back-pressure only applies to requests aimed at the IO region; the
  // region is judged from the request's first byte address.
  assign stall_new = (bus.LSBMC_addr[17:16] == IO_HI) && bus.io_buffer_full;
  assign stall_cur = (addr_q[17:16] == IO_HI) && bus.io_buffer_full;

  // Width 1 and 2 are honoured; every other encoding is a full word.
  always_comb begin
    n_dec = 3'd4;
    case (bus.LSBMC_data_width)
      3'd1:    n_dec = 3'd1;
      3'd2:    n_dec = 3'd2;
      default: n_dec = 3'd4;
    endcase
  end

  // Read buffer with the byte arriving this cycle merged in, so the final
  // byte can go straight into the response register.
  always_comb begin
    rd_next = rd_buf;
    rd_next[{cnt[1:0], 3'b000} +: 8] = bus.mem_din;
  end

  // Controller FSM. A write beat is presented on the bus one cycle before the
  // edge that commits it, so the first beat is set up on the accept edge; a
  // beat whose strobe was low (IO stall) is simply re-evaluated next edge.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      n_q      <= 3'd0;
      addr_q   <= '0;
      data_q   <= 32'd0;
      rd_buf   <= 32'd0;
      rdata_q  <= 32'd0;
      mem_a_q  <= '0;
      dout_q   <= 8'd0;
      mem_wr_q <= 1'b0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
    end else if (Sys_rdy) begin
      case (state)
        IDLE: begin
          if (bus.LSBMC_en) begin
            n_q     <= n_dec;
            addr_q  <= bus.LSBMC_addr;
            data_q  <= bus.LSBMC_data;
            cnt     <= 3'd0;
            rd_buf  <= 32'd0;
            mem_a_q <= bus.LSBMC_addr;
            if (bus.LSBMC_wr) begin
              dout_q   <= bus.LSBMC_data[7:0];
              mem_wr_q <= !stall_new;
              state    <= WRITE;
            end else begin
              mem_wr_q <= 1'b0;
              state    <= READ;
            end
          end
        end
        READ: begin
          rd_buf  <= rd_next;
          cnt     <= cnt_inc;
          mem_a_q <= next_a;
          if (cnt == last_cnt) begin
            rdata_q <= rd_next;
            r_en_q  <= 1'b1;
            state   <= DONE;
          end
        end
        WRITE: begin
          if (mem_wr_q) begin
            if (cnt == last_cnt) begin
              mem_wr_q <= 1'b0;
              w_en_q   <= 1'b1;
              state    <= DONE;
            end else begin
              cnt      <= cnt_inc;
              mem_a_q  <= next_a;
              dout_q   <= next_byte;
              mem_wr_q <= !stall_cur;
            end
          end else begin
            mem_wr_q <= !stall_cur;
          end
        end
        DONE: begin
          r_en_q <= 1'b0;
          w_en_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MCLSB_r_en = r_en_q;
  assign bus.MCLSB_w_en = w_en_q;
  assign bus.MCLSB_data = rdata_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = dout_q;
  // A frozen controller must never leave a write strobe on the bus.
  assign bus.mem_wr     = mem_wr_q & Sys_rdy;

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: self-checking bench for mem_controller. A 4 KiB byte RAM
// (address low 12 bits) answers the byte bus combinationally; each request
// pushes its expected cycle-by-cycle bus/response timeline into a queue that
// one compare process consumes, and directed literal checks pin key results.
module tb_mem_controller;

  logic clk;
  logic rst_n;
  logic rdy;

  mem_controller_if #(.ADDR_WIDTH(32)) bus ();

  mem_controller #(.ADDR_WIDTH(32), .IO_HI(2'b11)) dut (
    .Sys_clk   (clk),
    .Sys_rst_n (rst_n),
    .Sys_rdy   (rdy),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench RAM; preload port shares the single writing process with the DUT bus.
  logic [7:0]  ram [0:4095];
  logic        pl_we;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;

  assign bus.mem_din = ram[bus.mem_a[11:0]];

  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
  end

  typedef struct {
    bit          chk_a;
    logic [31:0] a;
    bit          chk_d;
    logic [7:0]  d;
    bit          wr;
    bit          r;
    bit          w;
    logic [31:0] data;
  } rec_t;

  rec_t exp_q[$];
  int   n_total = 0;
  int   n_fail  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int decode_n(input logic [2:0] w);
    if (w == 3'd1) return 1;
    if (w == 3'd2) return 2;
    return 4;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.chk_a = 0; r.a = 0; r.chk_d = 0; r.d = 0;
    r.wr = 0; r.r = 0; r.w = 0; r.data = 0;
    return r;
  endfunction

  // Read: address k shown after accept edge k, response N edges after accept.
  task automatic push_read(input logic [31:0] addr, input int n);
    rec_t r;
    logic [31:0] ak;
    logic [31:0] d;
    d = 32'd0;
    for (int k = 0; k < n; k++) begin
      ak = addr + k;
      r = idle_rec(); r.chk_a = 1; r.a = ak;
      exp_q.push_back(r);
      d[8*k +: 8] = ram[ak[11:0]];
    end
    r = idle_rec(); r.r = 1; r.data = d;
    exp_q.push_back(r);
    exp_q.push_back(idle_rec());
  endtask

  // Write: byte b is presented until an edge sees it unstalled; stalls apply
  // only to the IO region for the first 'stall' edges after accept.
  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input int n, input int stall);
    rec_t r;
    bit   io;
    bit   st;
    int   b;
    io = (addr[17:16] == 2'b11);
    b = 0;
    for (int k = 0; k < 64 && b < n; k++) begin
      st = io && (k < stall);
      r = idle_rec();
      r.chk_a = 1; r.a = addr + b;
      r.chk_d = 1; r.d = data[8*b +: 8];
      r.wr = !st;
      exp_q.push_back(r);
      if (!st) b++;
    end
    r = idle_rec(); r.w = 1;
    exp_q.push_back(r);
    exp_q.push_back(idle_rec());
  endtask

  // Compare process: sample 1 time unit after every rising edge.
  initial begin
    rec_t cur;
    logic [31:0] exp_data;
    bit rdy_e;
    cur = idle_rec();
    exp_data = 32'd0;
    forever begin
      @(posedge clk);
      rdy_e = rdy;
      #1;
      if (!rst_n) begin
        exp_data = 32'd0;
        cur = idle_rec();
        checkOutput("rst_r_en",   {31'd0, bus.MCLSB_r_en}, 32'd0);
        checkOutput("rst_w_en",   {31'd0, bus.MCLSB_w_en}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, bus.mem_wr},     32'd0);
        checkOutput("rst_data",   bus.MCLSB_data,          32'd0);
      end else begin
        if (rdy_e) cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
        else cur.wr = 0;
        if (cur.r) exp_data = cur.data;
        checkOutput("cyc_mem_wr", {31'd0, bus.mem_wr},     {31'd0, cur.wr});
        checkOutput("cyc_r_en",   {31'd0, bus.MCLSB_r_en}, {31'd0, cur.r});
        checkOutput("cyc_w_en",   {31'd0, bus.MCLSB_w_en}, {31'd0, cur.w});
        checkOutput("cyc_data",   bus.MCLSB_data,          exp_data);
        if (cur.chk_a) checkOutput("cyc_mem_a", bus.mem_a, cur.a);
        if (cur.chk_d) checkOutput("cyc_mem_dout", {24'd0, bus.mem_dout}, {24'd0, cur.d});
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one request, hold it until completion, optionally stall the IO sink
  // and/or drop Sys_rdy; lat = edges from accept to the completion pulse.
  task automatic applyStimulus(input bit wr, input logic [2:0] width, input logic [31:0] addr,
                               input logic [31:0] data, input int stall, input int rdy_at,
                               input int rdy_len, output int lat);
    bit done;
    @(negedge clk);
    bus.LSBMC_wr = wr; bus.LSBMC_data_width = width;
    bus.LSBMC_addr = addr; bus.LSBMC_data = data;
    bus.io_buffer_full = (stall > 0);
    bus.LSBMC_en = 1'b1;
    if (wr) push_write(addr, data, decode_n(width), stall);
    else    push_read(addr, decode_n(width));
    done = 0;
    lat = -1;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == stall) bus.io_buffer_full = 1'b0;
      if (cyc == rdy_at) rdy = 1'b0;
      if (cyc == rdy_at + rdy_len) rdy = 1'b1;
      if (bus.MCLSB_r_en || bus.MCLSB_w_en) begin
        done = 1;
        lat = cyc - 1;
        bus.LSBMC_en = 1'b0;
      end
    end
    bus.LSBMC_en = 1'b0;
    bus.io_buffer_full = 1'b0;
    rdy = 1'b1;
    checkOutput("completion_seen", {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int r_pulses;
    int w_cyc;
    bit done;
    rst_n = 1'b1; rdy = 1'b1; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    bus.LSBMC_en = 1'b0; bus.LSBMC_wr = 1'b0; bus.LSBMC_data_width = 3'd0;
    bus.LSBMC_data = 32'd0; bus.LSBMC_addr = 32'd0; bus.io_buffer_full = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_r_en",   {31'd0, bus.MCLSB_r_en}, 32'd0);
    checkOutput("reset_w_en",   {31'd0, bus.MCLSB_w_en}, 32'd0);
    checkOutput("reset_data",   bus.MCLSB_data,          32'd0);
    checkOutput("reset_dout",   {24'd0, bus.mem_dout},   32'd0);
    checkOutput("reset_mem_a",  bus.mem_a,               32'd0);
    checkOutput("reset_mem_wr", {31'd0, bus.mem_wr},     32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    preload(12'h100, 8'h11); preload(12'h101, 8'h22);
    preload(12'h102, 8'h33); preload(12'h103, 8'h44);
    preload(12'h007, 8'hF0); preload(12'h202, 8'h5A);
    preload(12'h242, 8'hEE);
    preload(12'hFFE, 8'hA1); preload(12'hFFF, 8'hB2);
    preload(12'h000, 8'hC3); preload(12'h001, 8'hD4);
    @(negedge clk);

    $display("[TB] read width 4 @0x100");
    applyStimulus(1'b0, 3'd4, 32'h100, 32'd0, 0, 0, 0, lat);
    checkOutput("rd4_latency", lat, 32'd4);
    checkOutput("rd4_data", bus.MCLSB_data, 32'h44332211);

    $display("[TB] read width 1 @0x7");
    applyStimulus(1'b0, 3'd1, 32'h7, 32'd0, 0, 0, 0, lat);
    checkOutput("rd1_latency", lat, 32'd1);
    checkOutput("rd1_data", bus.MCLSB_data, 32'h000000F0);

    $display("[TB] write width 2 @0x200");
    applyStimulus(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 0, 0, 0, lat);
    checkOutput("wr2_latency", lat, 32'd2);
    checkOutput("wr2_ram200", {24'd0, ram[12'h200]}, 32'hEF);
    checkOutput("wr2_ram201", {24'd0, ram[12'h201]}, 32'hBE);
    checkOutput("wr2_ram202", {24'd0, ram[12'h202]}, 32'h5A);
    checkOutput("wr2_data_held", bus.MCLSB_data, 32'h000000F0);

    $display("[TB] read odd width wrapping past the top address");
    applyStimulus(1'b0, 3'd7, 32'hFFFFFFFE, 32'd0, 0, 0, 0, lat);
    checkOutput("wrap_latency", lat, 32'd4);
    checkOutput("wrap_data", bus.MCLSB_data, 32'hD4C3B2A1);

    $display("[TB] IO write with 3 full cycles");
    applyStimulus(1'b1, 3'd1, 32'h30000, 32'h77, 3, 0, 0, lat);
    checkOutput("io_latency", lat, 32'd4);
    checkOutput("io_ram", {24'd0, ram[12'h000]}, 32'h77);

    $display("[TB] non-IO write ignores io_buffer_full");
    applyStimulus(1'b1, 3'd1, 32'h20005, 32'h66, 2, 0, 0, lat);
    checkOutput("nonio_latency", lat, 32'd1);
    checkOutput("nonio_ram", {24'd0, ram[12'h005]}, 32'h66);

    $display("[TB] write with Sys_rdy low for 2 cycles");
    applyStimulus(1'b1, 3'd2, 32'h220, 32'h1234, 0, 1, 2, lat);
    checkOutput("rdy_latency", lat, 32'd4);
    checkOutput("rdy_ram220", {24'd0, ram[12'h220]}, 32'h34);
    checkOutput("rdy_ram221", {24'd0, ram[12'h221]}, 32'h12);

    $display("[TB] flush: request dropped mid-read, write queued behind it");
    @(negedge clk);
    bus.LSBMC_wr = 1'b0; bus.LSBMC_data_width = 3'd4;
    bus.LSBMC_addr = 32'h100; bus.LSBMC_data = 32'd0;
    bus.LSBMC_en = 1'b1;
    push_read(32'h100, 4);
    r_pulses = 0; w_cyc = -1; done = 0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.LSBMC_en = 1'b0;
      if (cyc == 3) begin
        bus.LSBMC_wr = 1'b1; bus.LSBMC_data_width = 3'd2;
        bus.LSBMC_addr = 32'h210; bus.LSBMC_data = 32'h0000A55A;
        bus.LSBMC_en = 1'b1;
        push_write(32'h210, 32'h0000A55A, 2, 0);
      end
      if (bus.MCLSB_r_en) begin
        r_pulses++;
        checkOutput("flush_rd_data", bus.MCLSB_data, 32'h44332211);
      end
      if (bus.MCLSB_w_en) begin
        done = 1; w_cyc = cyc; bus.LSBMC_en = 1'b0;
      end
    end
    bus.LSBMC_en = 1'b0;
    checkOutput("flush_r_pulses", r_pulses, 32'd1);
    checkOutput("flush_w_cycle", w_cyc, 32'd9);
    repeat (2) @(negedge clk);
    checkOutput("flush_ram210", {24'd0, ram[12'h210]}, 32'h5A);
    checkOutput("flush_ram211", {24'd0, ram[12'h211]}, 32'hA5);

    $display("[TB] async reset in the middle of a word write");
    @(negedge clk);
    bus.LSBMC_wr = 1'b1; bus.LSBMC_data_width = 3'd4;
    bus.LSBMC_addr = 32'h240; bus.LSBMC_data = 32'h01020304;
    bus.LSBMC_en = 1'b1;
    push_write(32'h240, 32'h01020304, 4, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    bus.LSBMC_en = 1'b0;
    #1;
    checkOutput("mid_rst_mem_wr", {31'd0, bus.mem_wr},     32'd0);
    checkOutput("mid_rst_mem_a",  bus.mem_a,               32'd0);
    checkOutput("mid_rst_dout",   {24'd0, bus.mem_dout},   32'd0);
    checkOutput("mid_rst_w_en",   {31'd0, bus.MCLSB_w_en}, 32'd0);
    checkOutput("mid_rst_data",   bus.MCLSB_data,          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_ram240", {24'd0, ram[12'h240]}, 32'h04);
    checkOutput("mid_rst_ram241", {24'd0, ram[12'h241]}, 32'h03);
    checkOutput("mid_rst_ram242", {24'd0, ram[12'h242]}, 32'hEE);

    $display("[TB] request after reset");
    applyStimulus(1'b0, 3'd1, 32'h7, 32'd0, 0, 0, 0, lat);
    checkOutput("post_rst_latency", lat, 32'd1);
    checkOutput("post_rst_data", bus.MCLSB_data, 32'h000000F0);

    repeat (3) @(negedge clk);
    checkOutput("model_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
